// File: rtl/para_shift_engine.sv
// Parametrised bit-vector engine: parallel load plus burst shift/rotate with a start/busy/done handshake.
// Latency: start at edge t, steps at edges t+1..t+len, done high during cycle t+len+1 (len=0: done at t+1).
// Backpressure: none; start/load are only honoured in IDLE and are silently dropped while busy or done.
// Optional macro PARA_SHIFT_PARITY_EN adds a registered XOR-reduce 'parity' output tracking q.
module para_shift_engine #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned INIT  = 1,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             dir,
  input  logic             rot,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
`ifdef PARA_SHIFT_PARITY_EN
  ,
  output logic             parity
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] INIT_V = INIT[WIDTH-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic             sout_q, sout_d;
  logic             dir_q, dir_d;
  logic             rot_q, rot_d;

  logic             fill;
  logic             step_out;
  logic [WIDTH-1:0] step_vec;

  // Fill bit and outgoing bit for one step, using the direction/mode latched at start.
  always_comb begin
    fill     = sin;
    step_out = vec_q[WIDTH-1];
    if (dir_q) begin
      step_out = vec_q[0];
      fill     = rot_q ? vec_q[0] : sin;
    end else begin
      step_out = vec_q[WIDTH-1];
      fill     = rot_q ? vec_q[WIDTH-1] : sin;
    end
  end

  // A single-bit vector has nothing to slide: the fill bit simply becomes the new value.
  generate
    if (WIDTH == 1) begin : g_w1
      assign step_vec = fill;
    end else begin : g_wn
      assign step_vec = dir_q ? {fill, vec_q[WIDTH-1:1]} : {vec_q[WIDTH-2:0], fill};
    end
  endgenerate

  // Next-state and datapath update; load wins over start in IDLE, both ignored elsewhere.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    sout_d  = sout_q;
    dir_d   = dir_q;
    rot_d   = rot_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          vec_d = load_data;
        end else if (start) begin
          dir_d   = dir;
          rot_d   = rot;
          cnt_d   = len;
          state_d = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        vec_d  = step_vec;
        sout_d = step_out;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronous reset overrides everything, including a burst in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= INIT_V;
      sout_q  <= 1'b0;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      sout_q  <= sout_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
    end
  end

`ifdef PARA_SHIFT_PARITY_EN
  logic parity_q;

  // Parity is computed from the next vector so it changes on the same edge as q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_q <= ^INIT_V;
    end else begin
      parity_q <= ^vec_d;
    end
  end

  assign parity = parity_q;
`endif

  assign q    = vec_q;
  assign sout = sout_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule
